// File: rtl/time_set_controller_pkg.sv
// Shared time-field layout, limits, FSM encodings and field codes.
// Used by the time-set controller and the time/alarm blocks.
package time_set_controller_pkg;

    typedef struct packed {
        logic [2:0] day;
        logic [4:0] hour;
        logic [2:0] min_t;
        logic [3:0] min_u;
    } time_t;

    localparam logic [3:0] MIN_U_MAX = 4'd9;
    localparam logic [2:0] MIN_T_MAX = 3'd5;
    localparam logic [4:0] HOUR_MAX  = 5'd23;
    localparam logic [2:0] DAY_MAX   = 3'd6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ED_MIN = 3'd1;
    localparam logic [2:0] ST_ED_HR  = 3'd2;
    localparam logic [2:0] ST_ED_DAY = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    localparam logic [1:0] FLD_MIN  = 2'd0;
    localparam logic [1:0] FLD_HR   = 2'd1;
    localparam logic [1:0] FLD_DAY  = 2'd2;
    localparam logic [1:0] FLD_NONE = 2'd3;

    function automatic time_t sanitize(time_t t);
        time_t r;
        r = t;
        if (t.min_u > MIN_U_MAX) r.min_u = '0;
        if (t.min_t > MIN_T_MAX) r.min_t = '0;
        if (t.hour > HOUR_MAX)   r.hour  = '0;
        if (t.day > DAY_MAX)     r.day   = '0;
        return r;
    endfunction

    // Minute wraps 59 -> 00 without touching the hour.
    function automatic time_t inc_min(time_t t);
        time_t r;
        r = t;
        if (t.min_u >= MIN_U_MAX) begin
            r.min_u = '0;
            if (t.min_t >= MIN_T_MAX) r.min_t = '0;
            else r.min_t = t.min_t + 3'd1;
        end else begin
            r.min_u = t.min_u + 4'd1;
        end
        return r;
    endfunction

    function automatic time_t inc_hour(time_t t);
        time_t r;
        r = t;
        if (t.hour >= HOUR_MAX) r.hour = '0;
        else r.hour = t.hour + 5'd1;
        return r;
    endfunction

    function automatic time_t inc_day(time_t t);
        time_t r;
        r = t;
        if (t.day >= DAY_MAX) r.day = '0;
        else r.day = t.day + 3'd1;
        return r;
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button inputs, running time in, and the CTI/LD_CT/EN_CT load bundle out.
// Master drives buttons and CTO; slave is the controller.
interface time_set_controller_if;
    logic [14:0] CTO;
    logic        Set_Btn;
    logic        Next_Btn;
    logic        Inc_Btn;
    logic [14:0] CTI;
    logic        LD_CT;
    logic        EN_CT;
    logic        Edit;
    logic [1:0]  Field;

    modport master (
        output CTO, Set_Btn, Next_Btn, Inc_Btn,
        input  CTI, LD_CT, EN_CT, Edit, Field
    );

    modport slave (
        input  CTO, Set_Btn, Next_Btn, Inc_Btn,
        output CTI, LD_CT, EN_CT, Edit, Field
    );
endinterface

// File: rtl/time_set_controller_button_debouncer.sv
// Push-button debouncer: 2-flop synchroniser plus stable-high counter.
// Emits one press pulse per stable high level; release is immediate.
module button_debouncer
    import time_set_controller_pkg::*;
#(
    parameter int DEB_CNT = 50000,
    parameter int DEB_W   = 16
) (
    output logic press_o,
    input  logic Clk,
    input  logic Clr,
    input  logic raw_i
);

    localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [DEB_W-1:0] FULL = DEB_W'(DEB_CNT);

    logic             s1_q;
    logic             s2_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Counter saturates at FULL so a held button pulses only once.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!s2_q) begin
            cnt_d = '0;
        end else if (cnt_q != FULL) begin
            cnt_d   = cnt_q + 1'b1;
            press_d = (cnt_q == LAST);
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/time_set_controller.sv
// Time-set controller: captures CTO, edits min/hour/day with three
// buttons, then commits the edited value with a one-cycle LD_CT strobe.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter int DEB_CNT = 50000,
    parameter int DEB_W   = 16
) (
    input logic                  Clk,
    input logic                  Clr,
    time_set_controller_if.slave bus
);

    logic set_p;
    logic next_p;
    logic inc_p;

    button_debouncer #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_set (
        .press_o(set_p),
        .Clk    (Clk),
        .Clr    (Clr),
        .raw_i  (bus.Set_Btn)
    );

    button_debouncer #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_next (
        .press_o(next_p),
        .Clk    (Clk),
        .Clr    (Clr),
        .raw_i  (bus.Next_Btn)
    );

    button_debouncer #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_inc (
        .press_o(inc_p),
        .Clk    (Clk),
        .Clr    (Clr),
        .raw_i  (bus.Inc_Btn)
    );

    logic [2:0] state_q;
    logic [2:0] state_d;
    time_t      shadow_q;
    time_t      shadow_d;

    logic [14:0] cti_q;
    logic        ld_q;
    logic        ld_d;
    logic        en_q;
    logic        en_d;
    logic        edit_q;
    logic        edit_d;
    logic [1:0]  field_q;
    logic [1:0]  field_d;

    // Set beats Next beats Inc when pulses land in the same cycle.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        unique case (state_q)
            ST_IDLE: begin
                if (set_p) begin
                    state_d  = ST_ED_MIN;
                    shadow_d = sanitize(time_t'(bus.CTO));
                end
            end
            ST_ED_MIN: begin
                if (set_p)       state_d  = ST_COMMIT;
                else if (next_p) state_d  = ST_ED_HR;
                else if (inc_p)  shadow_d = inc_min(shadow_q);
            end
            ST_ED_HR: begin
                if (set_p)       state_d  = ST_COMMIT;
                else if (next_p) state_d  = ST_ED_DAY;
                else if (inc_p)  shadow_d = inc_hour(shadow_q);
            end
            ST_ED_DAY: begin
                if (set_p)       state_d  = ST_COMMIT;
                else if (next_p) state_d  = ST_ED_MIN;
                else if (inc_p)  shadow_d = inc_day(shadow_q);
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
        ld_d    = 1'b0;
        en_d    = 1'b0;
        edit_d  = 1'b0;
        field_d = FLD_NONE;
        unique case (state_d)
            ST_IDLE:   en_d = 1'b1;
            ST_ED_MIN: begin
                edit_d  = 1'b1;
                field_d = FLD_MIN;
            end
            ST_ED_HR: begin
                edit_d  = 1'b1;
                field_d = FLD_HR;
            end
            ST_ED_DAY: begin
                edit_d  = 1'b1;
                field_d = FLD_DAY;
            end
            ST_COMMIT: ld_d = 1'b1;
            default:   en_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            cti_q    <= '0;
            ld_q     <= 1'b0;
            en_q     <= 1'b1;
            edit_q   <= 1'b0;
            field_q  <= FLD_NONE;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cti_q    <= shadow_d;
            ld_q     <= ld_d;
            en_q     <= en_d;
            edit_q   <= edit_d;
            field_q  <= field_d;
        end
    end

    assign bus.CTI   = cti_q;
    assign bus.LD_CT = ld_q;
    assign bus.EN_CT = en_q;
    assign bus.Edit  = edit_q;
    assign bus.Field = field_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios plus random button
// sequences checked against an integer min/hour/day model.
module tb_time_set_controller;

    logic Clk = 1'b0;
    logic Clr = 1'b1;
    always #5 Clk = ~Clk;

    time_set_controller_if bus();

    time_set_controller #(.DEB_CNT(4), .DEB_W(4)) dut (
        .Clk(Clk),
        .Clr(Clr),
        .bus(bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int ld_cnt = 0;
    logic [14:0] ld_cti = '0;

    int m_mode = 0;
    int m_min = 0;
    int m_hr = 0;
    int m_day = 0;
    int exp_ld = 0;
    logic [14:0] exp_cti = '0;

    always @(negedge Clk) begin
        if (bus.LD_CT === 1'b1) begin
            ld_cnt++;
            ld_cti = bus.CTI;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] pack(input int mi, input int h,
                                         input int d);
        return 15'(d * 4096 + h * 128 + (mi / 10) * 16 + mi % 10);
    endfunction

    task automatic capture(input logic [14:0] cto);
        int u;
        int t;
        u = int'(cto[3:0]);
        t = int'(cto[6:4]);
        m_hr = int'(cto[11:7]);
        m_day = int'(cto[14:12]);
        if (u > 9) u = 0;
        if (t > 5) t = 0;
        if (m_hr > 23) m_hr = 0;
        if (m_day > 6) m_day = 0;
        m_min = t * 10 + u;
    endtask

    task automatic model_step(input bit s, input bit n, input bit i);
        if (s) begin
            if (m_mode == 0) begin
                capture(bus.CTO);
                m_mode = 1;
            end else begin
                exp_ld++;
                exp_cti = pack(m_min, m_hr, m_day);
                m_mode = 0;
            end
        end else if (n) begin
            if (m_mode != 0) m_mode = m_mode % 3 + 1;
        end else if (i) begin
            case (m_mode)
                1: m_min = (m_min + 1) % 60;
                2: m_hr = (m_hr + 1) % 24;
                3: m_day = (m_day + 1) % 7;
                default: ;
            endcase
        end
    endtask

    task automatic press(input bit s, input bit n, input bit i,
                         input int hold);
        @(posedge Clk);
        #1;
        bus.Set_Btn = s;
        bus.Next_Btn = n;
        bus.Inc_Btn = i;
        repeat (hold) @(posedge Clk);
        #1;
        bus.Set_Btn = 1'b0;
        bus.Next_Btn = 1'b0;
        bus.Inc_Btn = 1'b0;
        repeat (6) @(posedge Clk);
    endtask

    task automatic check_all(input string tag);
        @(negedge Clk);
        chk({tag, ".cti"}, 32'(bus.CTI), 32'(pack(m_min, m_hr, m_day)));
        chk({tag, ".edit"}, 32'(bus.Edit), 32'(m_mode != 0));
        chk({tag, ".en"}, 32'(bus.EN_CT), 32'(m_mode == 0));
        chk({tag, ".field"}, 32'(bus.Field),
            (m_mode == 0) ? 32'd3 : 32'(m_mode - 1));
        chk({tag, ".ldcnt"}, 32'(ld_cnt), 32'(exp_ld));
        if (exp_ld > 0) chk({tag, ".ldcti"}, 32'(ld_cti), 32'(exp_cti));
    endtask

    task automatic btn(input string tag, input bit s, input bit n,
                       input bit i);
        press(s, n, i, 6);
        model_step(s, n, i);
        check_all(tag);
    endtask

    initial begin
        bus.CTO = '0;
        bus.Set_Btn = 1'b0;
        bus.Next_Btn = 1'b0;
        bus.Inc_Btn = 1'b0;

        // Reset held while buttons wiggle
        repeat (12) begin
            @(posedge Clk);
            #1;
            bus.Set_Btn = 1'($urandom);
            bus.Next_Btn = 1'($urandom);
            bus.Inc_Btn = 1'($urandom);
        end
        @(negedge Clk);
        chk("rst.ld", 32'(bus.LD_CT), 32'd0);
        chk("rst.en", 32'(bus.EN_CT), 32'd1);
        chk("rst.cti", 32'(bus.CTI), 32'h0);
        chk("rst.edit", 32'(bus.Edit), 32'd0);
        chk("rst.field", 32'(bus.Field), 32'd3);
        bus.Set_Btn = 1'b0;
        bus.Next_Btn = 1'b0;
        bus.Inc_Btn = 1'b0;
        Clr = 1'b0;
        repeat (20) @(posedge Clk);
        check_all("rel");

        // Minute wrap
        bus.CTO = 15'h3759;
        btn("mw.set", 1, 0, 0);
        btn("mw.inc", 0, 0, 1);
        btn("mw.commit", 1, 0, 0);
        chk("mw.cti", 32'(ld_cti), 32'h3700);
        chk("mw.en", 32'(bus.EN_CT), 32'd1);

        // Hour and day wrap
        bus.CTO = 15'h6BA3;
        btn("hd.set", 1, 0, 0);
        btn("hd.next1", 0, 1, 0);
        btn("hd.inch", 0, 0, 1);
        btn("hd.next2", 0, 1, 0);
        btn("hd.incd", 0, 0, 1);
        btn("hd.commit", 1, 0, 0);
        chk("hd.cti", 32'(ld_cti), 32'h0023);

        // Bounce: short pulses must not count
        bus.CTO = 15'h1234;
        btn("bn.set", 1, 0, 0);
        repeat (3) press(0, 0, 1, 3);
        check_all("bn.short");
        btn("bn.long", 0, 0, 1);
        btn("bn.commit", 1, 0, 0);

        // Set and Inc together: Set wins
        bus.CTO = 15'h2517;
        btn("co.set", 1, 0, 0);
        btn("co.both", 1, 0, 1);

        // Reset mid-edit
        bus.CTO = 15'h0845;
        btn("mr.set", 1, 0, 0);
        btn("mr.next", 0, 1, 0);
        btn("mr.inc", 0, 0, 1);
        @(posedge Clk);
        #1;
        Clr = 1'b1;
        #2;
        chk("mr.edit", 32'(bus.Edit), 32'd0);
        chk("mr.en", 32'(bus.EN_CT), 32'd1);
        chk("mr.cti", 32'(bus.CTI), 32'h0);
        chk("mr.field", 32'(bus.Field), 32'd3);
        chk("mr.ld", 32'(bus.LD_CT), 32'd0);
        m_mode = 0;
        m_min = 0;
        m_hr = 0;
        m_day = 0;
        repeat (3) @(posedge Clk);
        #1;
        Clr = 1'b0;
        repeat (4) @(posedge Clk);
        check_all("mr.after");

        // Random sequences against the model
        for (int k = 0; k < 60; k++) begin
            int r;
            bus.CTO = 15'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 3)      btn("rnd.set", 1, 0, 0);
            else if (r < 5) btn("rnd.next", 0, 1, 0);
            else if (r < 8) btn("rnd.inc", 0, 0, 1);
            else if (r < 9) btn("rnd.si", 1, 0, 1);
            else            btn("rnd.ni", 0, 1, 1);
        end
        if (m_mode != 0) btn("rnd.close", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
